id_pipe_stage: RTL and testbench

ID_PIPE_STAGE -- requirements
Module: id_pipe_stage

---
 rtl/r2rv_pkg.sv | 65 ++++++
 rtl/id_regfile.sv | 41 ++++
 rtl/id_scoreboard.sv | 62 ++++++
 rtl/id_pipe_stage.sv | 150 +++++++++++++++
 tb/tb_id_pipe_stage.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r2rv_pkg.sv
// Shared decode types for the RV32I decode stage: opcodes, selectors,
// immediate formats and the decode-to-execute bundle.
package r2rv_pkg;

    localparam int B_XLEN = 32;
    localparam int B_AW   = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SRC1_REG, SRC1_PC, SRC1_ZERO
    } src1_sel_e;

    typedef enum logic {
        SRC2_REG, SRC2_IMM
    } src2_sel_e;

    typedef enum logic [1:0] {
        WD3_ALU, WD3_MEM, WD3_PC4
    } wd3_sel_e;

    typedef struct packed {
        src1_sel_e          src1_selector;
        src2_sel_e          src2_selector;
        wd3_sel_e           wd3_selector;
        logic               we3;
        logic               wem;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [B_AW-1:0]    wa3;
        logic [B_XLEN-1:0]  imm;
        logic [B_XLEN-1:0]  rd1;
        logic [B_XLEN-1:0]  rd2;
    } id_bundle_t;

    function automatic logic [B_XLEN-1:0] imm_gen(
        input logic [31:0] i,
        input imm_fmt_e    f
    );
        logic [B_XLEN-1:0] r;
        r = '0;
        unique case (f)
            IMM_I: r = B_XLEN'($signed(i[31:20]));
            IMM_S: r = B_XLEN'($signed({i[31:25], i[11:7]}));
            IMM_B: r = B_XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            IMM_U: r = B_XLEN'($signed({i[31:12], 12'b0}));
            IMM_J: r = B_XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Architectural register file, x0 hardwired to zero, with optional
// write-through of the writeback port onto the read ports.
module id_regfile
    import r2rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (BYPASS != 0 && we && wa == ra1) rd1 = wd;
        if (BYPASS != 0 && we && wa == ra2) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/id_scoreboard.sv
// Per-register busy tracking for in-flight writers and the issue
// hazard check against busy and just-decoded destinations.
module id_scoreboard #(
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic [AW-1:0]   rs1,
    input  logic            rs1_used,
    input  logic [AW-1:0]   rs2,
    input  logic            rs2_used,
    input  logic [AW-1:0]   rd,
    input  logic            rd_used,
    input  logic            pend_valid,
    input  logic [AW-1:0]   pend_addr,
    output logic            hazard,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] busy_eff;
    logic [NREG-1:0] src_busy;
    logic            h1, h2, h3;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && set_addr != '0) set_vec[set_addr] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;
    end

    // Without write-through the freed value is not visible yet.
    assign busy_eff = busy & ~clr_vec;
    assign src_busy = (BYPASS != 0) ? busy_eff : busy;

    assign h1 = rs1_used && rs1 != '0 &&
                (src_busy[rs1] || (pend_valid && pend_addr == rs1));
    assign h2 = rs2_used && rs2 != '0 &&
                (src_busy[rs2] || (pend_valid && pend_addr == rs2));
    assign h3 = rd_used && rd != '0 &&
                (busy_eff[rd] || (pend_valid && pend_addr == rd));
    assign hazard = h1 || h2 || h3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: rtl/id_pipe_stage.sv
// RV32I decode stage: decodes, reads operands, checks the scoreboard
// and holds one decoded bundle behind a valid/ready handshake.
module id_pipe_stage
    import r2rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    output logic            out_valid,
    input  logic            out_ready,
    output id_bundle_t      out_bundle
);

    logic [6:0]      op;
    logic [AW-1:0]   ra1, ra2, rd;
    logic [XLEN-1:0] rd1, rd2;
    id_bundle_t      dec;
    imm_fmt_e        fmt;
    logic            uses_rs1, uses_rs2;
    logic            hazard;
    logic            tin, tout;
    logic [NREG-1:0] busy;

    assign op  = instr[6:0];
    assign ra1 = instr[15 +: AW];
    assign ra2 = instr[20 +: AW];
    assign rd  = instr[7 +: AW];

    assign uses_rs1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
    assign uses_rs2 = op == OPC_OP || op == OPC_STORE || op == OPC_BRANCH;

    always_comb begin
        dec        = '0;
        fmt        = IMM_NONE;
        dec.funct3 = instr[14:12];
        dec.funct7 = instr[31:25];
        dec.wa3    = instr[11:7];
        dec.rd1    = B_XLEN'(rd1);
        dec.rd2    = B_XLEN'(rd2);
        unique case (1'b1)
            op == OPC_LUI: begin
                dec.we3 = 1'b1;
                dec.src1_selector = SRC1_ZERO;
                dec.src2_selector = SRC2_IMM;
                fmt = IMM_U;
            end
            op == OPC_AUIPC: begin
                dec.we3 = 1'b1;
                dec.src1_selector = SRC1_PC;
                dec.src2_selector = SRC2_IMM;
                fmt = IMM_U;
            end
            op == OPC_JAL: begin
                dec.we3 = 1'b1;
                dec.src1_selector = SRC1_PC;
                dec.src2_selector = SRC2_IMM;
                dec.wd3_selector = WD3_PC4;
                fmt = IMM_J;
            end
            op == OPC_JALR: begin
                dec.we3 = 1'b1;
                dec.src2_selector = SRC2_IMM;
                dec.wd3_selector = WD3_PC4;
                fmt = IMM_I;
            end
            op == OPC_BRANCH: fmt = IMM_B;
            op == OPC_LOAD: begin
                dec.we3 = 1'b1;
                dec.src2_selector = SRC2_IMM;
                dec.wd3_selector = WD3_MEM;
                fmt = IMM_I;
            end
            op == OPC_STORE: begin
                dec.wem = 1'b1;
                dec.src2_selector = SRC2_IMM;
                fmt = IMM_S;
            end
            op == OPC_OPIMM: begin
                dec.we3 = 1'b1;
                dec.src2_selector = SRC2_IMM;
                fmt = IMM_I;
            end
            op == OPC_OP: dec.we3 = 1'b1;
            default: ;
        endcase
        dec.imm = imm_gen(instr, fmt);
    end

    id_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS)) u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (wb_we),
        .wa    (wb_wa),
        .wd    (wb_wd),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    id_scoreboard #(.NREG(NREG), .BYPASS(BYPASS)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .set_en     (tout && out_bundle.we3),
        .set_addr   (AW'(out_bundle.wa3)),
        .clr_en     (wb_we),
        .clr_addr   (wb_wa),
        .rs1        (ra1),
        .rs1_used   (uses_rs1),
        .rs2        (ra2),
        .rs2_used   (uses_rs2),
        .rd         (rd),
        .rd_used    (dec.we3),
        .pend_valid (out_valid && out_bundle.we3),
        .pend_addr  (AW'(out_bundle.wa3)),
        .hazard     (hazard),
        .busy       (busy)
    );

    assign in_ready = reset && (!out_valid || out_ready) && !hazard && !flush;
    assign tin      = in_valid && in_ready;
    assign tout     = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_bundle <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (tin) begin
            out_valid  <= 1'b1;
            out_bundle <= dec;
        end else if (tout) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Randomised and directed bench for id_pipe_stage against a
// transaction-level model of decode, register state and busy tracking.
module tb_id_pipe_stage;
    import r2rv_pkg::*;

    localparam int BYPASS_TB = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_wa = '0;
    logic [31:0] wb_wd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    id_bundle_t  out_bundle;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_ov;
    id_bundle_t  m_ob;

    id_pipe_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bundle (out_bundle)
    );

    always #5 clk = ~clk;

    function automatic id_bundle_t ref_decode(input logic [31:0] i,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        id_bundle_t e;
        logic [31:0] ii, is, ib, ij;
        ii = 32'(i[30:20]) - (i[31] ? 32'd2048 : 32'd0);
        is = 32'({i[30:25], i[11:7]}) - (i[31] ? 32'd2048 : 32'd0);
        ib = 32'({i[7], i[30:25], i[11:8], 1'b0}) - (i[31] ? 32'd4096 : 32'd0);
        ij = 32'({i[19:12], i[20], i[30:21], 1'b0}) - (i[31] ? 32'h100000 : 32'd0);
        e = '0;
        e.funct3 = i[14:12];
        e.funct7 = i[31:25];
        e.wa3 = i[11:7];
        e.rd1 = a;
        e.rd2 = b;
        case (i[6:0])
            OPC_LUI: begin
                e.we3 = 1; e.src1_selector = SRC1_ZERO;
                e.src2_selector = SRC2_IMM; e.imm = i & 32'hFFFFF000;
            end
            OPC_AUIPC: begin
                e.we3 = 1; e.src1_selector = SRC1_PC;
                e.src2_selector = SRC2_IMM; e.imm = i & 32'hFFFFF000;
            end
            OPC_JAL: begin
                e.we3 = 1; e.src1_selector = SRC1_PC; e.src2_selector = SRC2_IMM;
                e.wd3_selector = WD3_PC4; e.imm = ij;
            end
            OPC_JALR: begin
                e.we3 = 1; e.src2_selector = SRC2_IMM;
                e.wd3_selector = WD3_PC4; e.imm = ii;
            end
            OPC_BRANCH: e.imm = ib;
            OPC_LOAD: begin
                e.we3 = 1; e.src2_selector = SRC2_IMM;
                e.wd3_selector = WD3_MEM; e.imm = ii;
            end
            OPC_STORE: begin
                e.wem = 1; e.src2_selector = SRC2_IMM; e.imm = is;
            end
            OPC_OPIMM: begin
                e.we3 = 1; e.src2_selector = SRC2_IMM; e.imm = ii;
            end
            OPC_OP: e.we3 = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] ref_read(input int r);
        if (r == 0) return 32'd0;
        if (BYPASS_TB != 0 && wb_we && int'(wb_wa) == r) return wb_wd;
        return m_regs[r];
    endfunction

    function automatic bit in_flight(input int r);
        return m_ov && m_ob.we3 && int'(m_ob.wa3) == r;
    endfunction

    function automatic bit wb_hits(input int r);
        return wb_we && int'(wb_wa) == r;
    endfunction

    function automatic bit model_ready();
        logic [6:0] op;
        int r1, r2, rd;
        bit u1, u2, w, stall;
        op = instr[6:0];
        r1 = int'(instr[19:15]);
        r2 = int'(instr[24:20]);
        rd = int'(instr[11:7]);
        stall = 0;
        if (!reset || flush) return 0;
        if (m_ov && !out_ready) return 0;
        u1 = !(op inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        u2 = op inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        w  = op inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                        OPC_LOAD, OPC_OPIMM, OPC_OP};
        if (u1 && r1 != 0 && ((m_busy[r1] && !(BYPASS_TB != 0 && wb_hits(r1)))
                              || in_flight(r1))) stall = 1;
        if (u2 && r2 != 0 && ((m_busy[r2] && !(BYPASS_TB != 0 && wb_hits(r2)))
                              || in_flight(r2))) stall = 1;
        if (w && rd != 0 && ((m_busy[rd] && !wb_hits(rd)) || in_flight(rd)))
            stall = 1;
        return !stall;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        m_busy = '0;
        m_ov = 0;
        m_ob = '0;
    endtask

    task automatic tick();
        bit rdy, tin, tout, nov;
        id_bundle_t nob;
        #1;
        rdy = model_ready();
        checks++;
        if (in_ready !== rdy) begin
            failures++;
            $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, rdy);
        end
        tin = in_valid && rdy;
        tout = m_ov && out_ready;
        nob = m_ob;
        nov = m_ov;
        if (flush) begin
            nov = 0;
        end else if (tin) begin
            nob = ref_decode(instr, ref_read(int'(instr[19:15])),
                             ref_read(int'(instr[24:20])));
            nov = 1;
        end else if (tout) begin
            nov = 0;
        end
        if (flush) begin
            m_busy = '0;
        end else begin
            if (wb_we) m_busy[wb_wa] = 1'b0;
            if (tout && m_ob.we3 && m_ob.wa3 != 0) m_busy[m_ob.wa3] = 1'b1;
        end
        if (wb_we && wb_wa != 0) m_regs[wb_wa] = wb_wd;
        m_ob = nob;
        m_ov = nov;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== m_ov) begin
            failures++;
            $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, m_ov);
        end
        if (m_ov) begin
            checks++;
            if (out_bundle !== m_ob) begin
                failures++;
                $display("FAIL bundle t=%0t got=%h exp=%h", $time, out_bundle, m_ob);
            end
        end
        checks++;
        if (dut.u_sb.busy !== m_busy) begin
            failures++;
            $display("FAIL busy t=%0t got=%h exp=%h", $time, dut.u_sb.busy, m_busy);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0;
        flush = 0;
        wb_we = 0;
        wb_wa = '0;
        wb_wd = '0;
        out_ready = 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 0;
        idle_inputs();
        model_clear();
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 0;
        idle_inputs();
        in_valid = 1;
        instr = 32'h00500093;
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_bundle !== '0) begin
            failures++; $display("FAIL rst_bundle got=%h exp=0", out_bundle);
        end
        @(negedge clk);
        reset = 1;
        in_valid = 0;
    endtask

    task automatic test_addi();
        apply_reset();
        in_valid = 1;
        instr = 32'h00500093;
        tick();
        checks++;
        if (out_valid !== 1 || out_bundle.imm !== 32'd5 ||
            out_bundle.wa3 !== 5'd1 || out_bundle.we3 !== 1'b1) begin
            failures++;
            $display("FAIL addi_fields v=%b imm=%h wa3=%0d we3=%b exp 1/5/1/1",
                     out_valid, out_bundle.imm, out_bundle.wa3, out_bundle.we3);
        end
        in_valid = 0;
        tick();
        checks++;
        if (dut.u_sb.busy[1] !== 1'b1) begin
            failures++; $display("FAIL addi_busy1 got=%b exp=1", dut.u_sb.busy[1]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        in_valid = 1;
        instr = 32'h00500093;
        tick();
        instr = 32'h00108133;
        tick();
        tick();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_stall got=%b exp=0", in_ready);
        end
        wb_we = 1;
        wb_wa = 5'd1;
        wb_wd = 32'd5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_release got=%b exp=1", in_ready);
        end
        tick();
        wb_we = 0;
        in_valid = 0;
        checks++;
        if (out_bundle.rd1 !== 32'd5 || out_bundle.rd2 !== 32'd5) begin
            failures++;
            $display("FAIL b2b_bypass rd1=%h rd2=%h exp=5/5",
                     out_bundle.rd1, out_bundle.rd2);
        end
        tick();
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 0;
        in_valid = 1;
        instr = 32'h00700193;
        tick();
        instr = 32'h00900213;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (in_ready !== 1'b0 || out_bundle.imm !== 32'd7) begin
                failures++;
                $display("FAIL stall_hold rdy=%b imm=%h exp 0/7", in_ready, out_bundle.imm);
            end
        end
        out_ready = 1;
        tick();
        in_valid = 0;
        checks++;
        if (out_bundle.imm !== 32'd9 || out_bundle.wa3 !== 5'd4) begin
            failures++;
            $display("FAIL stall_next imm=%h wa3=%0d exp 9/4", out_bundle.imm, out_bundle.wa3);
        end
        tick();
    endtask

    task automatic test_x0();
        apply_reset();
        wb_we = 1;
        wb_wa = 5'd0;
        wb_wd = 32'hDEADBEEF;
        tick();
        wb_we = 0;
        in_valid = 1;
        instr = 32'h00000313;
        tick();
        checks++;
        if (out_bundle.rd1 !== 32'd0) begin
            failures++; $display("FAIL x0_read got=%h exp=0", out_bundle.rd1);
        end
        wb_we = 1;
        instr = 32'h000003B3;
        tick();
        checks++;
        if (out_bundle.rd1 !== 32'd0 || out_bundle.rd2 !== 32'd0) begin
            failures++;
            $display("FAIL x0_bypass rd1=%h rd2=%h exp=0/0", out_bundle.rd1, out_bundle.rd2);
        end
        wb_we = 0;
        instr = 32'h00100013;
        tick();
        in_valid = 0;
        tick();
        checks++;
        if (dut.u_sb.busy[0] !== 1'b0) begin
            failures++; $display("FAIL x0_busy got=%b exp=0", dut.u_sb.busy[0]);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        in_valid = 1;
        instr = 32'h00100193;
        tick();
        out_ready = 0;
        instr = 32'h00200413;
        tick();
        flush = 1;
        instr = 32'h00300493;
        tick();
        flush = 0;
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b0 || dut.u_sb.busy !== '0) begin
            failures++;
            $display("FAIL flush_clear v=%b busy=%h exp 0/0", out_valid, dut.u_sb.busy);
        end
        out_ready = 1;
        in_valid = 1;
        instr = 32'h40318233;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_accept got=%b exp=1", in_ready);
        end
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_bundle.funct7 !== 7'h20) begin
            failures++;
            $display("FAIL flush_sub v=%b f7=%h exp 1/20", out_valid, out_bundle.funct7);
        end
        tick();
    endtask

    task automatic test_set_wins();
        apply_reset();
        out_ready = 0;
        in_valid = 1;
        instr = 32'h00100293;
        tick();
        in_valid = 0;
        out_ready = 1;
        wb_we = 1;
        wb_wa = 5'd5;
        wb_wd = 32'h1234;
        tick();
        wb_we = 0;
        checks++;
        if (dut.u_sb.busy[5] !== 1'b1) begin
            failures++; $display("FAIL set_wins got=%b exp=1", dut.u_sb.busy[5]);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 0;
        in_valid = 1;
        instr = 32'h00700193;
        tick();
        reset = 0;
        model_clear();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset v=%b rdy=%b exp 0/0", out_valid, in_ready);
        end
        @(negedge clk);
        reset = 1;
        out_ready = 1;
        instr = 32'h00900213;
        tick();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_bundle.imm !== 32'd9) begin
            failures++;
            $display("FAIL mid_capture v=%b imm=%h exp 1/9", out_valid, out_bundle.imm);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] w;
        int bq [$];
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, 7'b1110011};
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 9)];
            w[11:7] = 5'($urandom_range(0, 7));
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            instr = w;
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            wb_we = ($urandom_range(0, 2) == 0);
            bq.delete();
            for (int r = 0; r < 32; r++) if (m_busy[r]) bq.push_back(r);
            if (bq.size() != 0 && $urandom_range(0, 3) != 0)
                wb_wa = 5'(bq[$urandom_range(0, bq.size() - 1)]);
            else
                wb_wa = 5'($urandom_range(0, 7));
            wb_wd = $urandom;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_x0();
        test_flush();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
